// File: rtl/input_debouncer.sv
// Two-flop synchronized, counter-qualified switch debouncer with optional Rise/Fall edge pulses (INPUT_DEBOUNCER_EDGE_EN).
// Latency: Dout follows a clean Din step on the (STABLE_CYCLES+2)th rising Clk edge; Rise/Fall are valid the cycle after.
// Backpressure: none; Din is sampled every cycle and the outputs are free-running levels and pulses.
module input_debouncer #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Din,
    output logic Dout,
    output logic Dout_n,
    output logic Rise,
    output logic Fall
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_q, s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_d, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s2_q) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                dout_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            s1_q    <= Din;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign Dout   = dout_q;
    assign Dout_n = ~dout_q;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign Rise = rise_q;
    assign Fall = fall_q;
`else
    // Edge detection is compiled out; the decode above has no remaining load.
    logic unused_edge;
    assign unused_edge = rise_d ^ fall_d;
    assign Rise = 1'b0;
    assign Fall = 1'b0;
`endif

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named Clk and Reset as elsewhere in the codebase.
REQ-002 Parameter STABLE_CYCLES, default 8: consecutive synchronized samples needed to accept a new level; legal range 2..(2^CNT_W - 1).
REQ-003 Parameter CNT_W, default 4: width of the stability counter.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous, active-low reset; 0 forces reset state.
REQ-006 Din  input  1  raw asynchronous level, e.g. a switch or external pin.
REQ-007 Dout  output  1  debounced, synchronized level; drives the D input of the downstream flip-flop stage.
REQ-008 Dout_n  output  1  always the complement of Dout.
REQ-009 Rise  output  1  one-cycle pulse when Dout goes 0->1.
REQ-010 Fall  output  1  one-cycle pulse when Dout goes 1->0.

Function
REQ-011 Din SHALL pass through a two-flop synchronizer (s1 then s2); only s2 feeds the rest of the logic.
REQ-012 The FSM SHALL have four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW; Dout is 1 only in IDLE_HIGH and WAIT_LOW.
REQ-013 In IDLE_LOW with s2=1, the FSM SHALL go to WAIT_HIGH and load cnt=1; IDLE_HIGH with s2=0 behaves the same way, going to WAIT_LOW.
REQ-014 In a WAIT state, if s2 equals Dout, the FSM SHALL return to the matching IDLE state with cnt=0 and Dout unchanged (glitch rejected).
REQ-015 In a WAIT state, if s2 differs from Dout and cnt < STABLE_CYCLES-1, cnt SHALL increment by 1.
REQ-016 In a WAIT state, if s2 differs from Dout and cnt = STABLE_CYCLES-1, Dout SHALL toggle on that edge, the FSM goes to the opposite IDLE state, and cnt clears to 0.
REQ-017 Latency: a clean Din step SHALL change Dout on exactly the (STABLE_CYCLES+2)th rising Clk edge after the step (10 edges at default).
REQ-018 A Din pulse lasting fewer than STABLE_CYCLES Clk periods at s2 SHALL NOT change Dout.
REQ-019 cnt SHALL never wrap; it is bounded by STABLE_CYCLES-1 per REQ-016.
REQ-020 Rise/Fall SHALL be registered, asserted for exactly the one cycle after the edge where Dout toggles, and never both 1 at once.
REQ-021 Dout, Dout_n, Rise and Fall SHALL be glitch-free register outputs; Dout_n is derived from the Dout register.

Reset
REQ-022 When Reset=0, the block SHALL asynchronously set s1=0, s2=0, state=IDLE_LOW, cnt=0, Dout=0, Dout_n=1, Rise=0, Fall=0.
REQ-023 Reset asserted during a WAIT state SHALL abandon the pending transition without emitting any Rise or Fall pulse.
REQ-024 After Reset is released with Din=1 held, Dout SHALL rise per REQ-017, counting from the first rising edge after release, and Rise SHALL pulse once.

Configuration
REQ-025 Macro INPUT_DEBOUNCER_EDGE_EN: when defined, Rise/Fall SHALL behave per REQ-020.
REQ-026 When INPUT_DEBOUNCER_EDGE_EN is not defined, Rise and Fall SHALL remain present as ports, be tied to constant 0, and no edge registers are synthesized; all other behaviour is identical.

Verification (Clk period 20 ns, STABLE_CYCLES=8, INPUT_DEBOUNCER_EDGE_EN defined unless stated)
REQ-027 Hold Reset=0 for 100 ns with Din=1 -> Dout=0, Dout_n=1, Rise=Fall=0 throughout.
REQ-028 Release Reset, hold Din=1 -> Dout=1 on the 10th rising edge after the edge that samples the release; Rise=1 for one cycle only.
REQ-029 With Dout=1, drive Din=0 for 100 ns (5 cycles), then back to 1 -> Dout stays 1, Fall never asserts.
REQ-030 Toggle Din every 80 ns (4 cycles), as in the flip-flop bench -> Dout never changes.
REQ-031 Start a 1->0 transition, then assert Reset at cnt=5 -> Dout=0 immediately, Fall never asserts, state=IDLE_LOW.
REQ-032 Rerun REQ-028 without INPUT_DEBOUNCER_EDGE_EN -> Dout timing unchanged; Rise and Fall stay 0.
